bist_scan_sequencer: RTL

- Control FSM that sequences one BIST-per-scan session: LFSR seed load, scan shift, capture, MISR compaction and final signature compare.
- Sits beside the LFSR, scan chain and MISR inside the BIST top level.
- Drives the pattern-generator, chain and compactor enables.
- Reports bist_end and pass_nfail to the top-level ports.

---
 rtl/bist_scan_sequencer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/bist_scan_sequencer.sv
// Session sequencer for BIST-per-scan: seed load, scan shift, capture, MISR compaction, signature compare.
// Optional build macro BIST_ABORT_EN adds a bist_abort input and an aborted status output.
module bist_scan_sequencer #(
    parameter int                   CHAIN_LEN    = 8,
    parameter int                   NUM_PATTERNS = 64,
    parameter int                   SIG_WIDTH    = 16,
    parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG   = 16'h0000,
    localparam int                  PCW          = $clog2(NUM_PATTERNS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 bist_start,
    input  logic [SIG_WIDTH-1:0] misr_sig,
`ifdef BIST_ABORT_EN
    input  logic                 bist_abort,
    output logic                 aborted,
`endif
    output logic                 lfsr_seed_load,
    output logic                 lfsr_en,
    output logic                 scan_en,
    output logic                 capture_en,
    output logic                 misr_clear,
    output logic                 misr_en,
    output logic                 busy,
    output logic [PCW-1:0]       pattern_cnt,
    output logic                 bist_end,
    output logic                 pass_nfail
);

    localparam int             SCW        = $clog2(CHAIN_LEN);
    localparam logic [SCW-1:0] SHIFT_LAST = SCW'(CHAIN_LEN - 1);
    localparam logic [PCW-1:0] PAT_LAST   = PCW'(NUM_PATTERNS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [SCW-1:0] r_shift_cnt;
    logic [SCW-1:0] w_shift_nxt;
    logic [PCW-1:0] w_pcnt_nxt;
    logic           r_start_q;
    logic           w_start_evt;
    logic           w_abort;
    logic           w_abortable;
    logic           w_pass_nxt;
    logic           w_seed_nxt;
    logic           w_lfsr_nxt;
    logic           w_scan_nxt;
    logic           w_cap_nxt;
    logic           w_clr_nxt;
    logic           w_misr_nxt;
    logic           w_busy_nxt;
    logic           w_end_nxt;
`ifdef BIST_ABORT_EN
    logic           w_aborted_nxt;
`endif

    assign w_start_evt = bist_start & ~r_start_q;
    assign w_abortable = (r_state == S_INIT) || (r_state == S_SHIFT) || (r_state == S_CAPTURE);
`ifdef BIST_ABORT_EN
    assign w_abort = bist_abort;
`else
    assign w_abort = 1'b0;
`endif

    // Next state, counters and result register.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift_cnt;
        w_pcnt_nxt  = pattern_cnt;
        w_pass_nxt  = pass_nfail;
`ifdef BIST_ABORT_EN
        w_aborted_nxt = aborted;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_start_evt) begin
                    w_state_nxt = S_INIT;
`ifdef BIST_ABORT_EN
                    w_aborted_nxt = 1'b0;
`endif
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_INIT: begin
                w_state_nxt = S_SHIFT;
                w_shift_nxt = {SCW{1'b0}};
                w_pcnt_nxt  = {PCW{1'b0}};
            end
            S_SHIFT: begin
                if (r_shift_cnt == SHIFT_LAST) begin
                    w_shift_nxt = {SCW{1'b0}};
                    if (pattern_cnt == PAT_LAST) begin
                        w_state_nxt = S_COMPARE;
                    end else begin
                        w_state_nxt = S_CAPTURE;
                    end
                end else begin
                    w_shift_nxt = r_shift_cnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = S_SHIFT;
                if (pattern_cnt != PAT_LAST) begin
                    w_pcnt_nxt = pattern_cnt + 1'b1;
                end else begin
                    w_pcnt_nxt = pattern_cnt;
                end
            end
            S_COMPARE: begin
                w_state_nxt = S_DONE;
                w_pass_nxt  = (misr_sig == GOLDEN_SIG);
            end
            S_DONE: begin
                if (!bist_start) begin
                    w_state_nxt = S_IDLE;
                    w_pcnt_nxt  = {PCW{1'b0}};
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // An abort skips the remaining patterns; the interrupted capture is not counted.
        if (w_abort && w_abortable) begin
            w_state_nxt = S_DONE;
            w_shift_nxt = {SCW{1'b0}};
            w_pcnt_nxt  = pattern_cnt;
            w_pass_nxt  = 1'b0;
`ifdef BIST_ABORT_EN
            w_aborted_nxt = 1'b1;
`endif
        end else begin
            w_pass_nxt = w_pass_nxt;
        end
    end

    // Control enables for the upcoming cycle, decoded from the next state so they leave as flops.
    always_comb begin
        w_seed_nxt = 1'b0;
        w_lfsr_nxt = 1'b0;
        w_scan_nxt = 1'b0;
        w_cap_nxt  = 1'b0;
        w_clr_nxt  = 1'b0;
        w_misr_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        w_end_nxt  = 1'b0;
        case (w_state_nxt)
            S_INIT: begin
                w_seed_nxt = 1'b1;
                w_clr_nxt  = 1'b1;
                w_busy_nxt = 1'b1;
            end
            S_SHIFT: begin
                w_scan_nxt = 1'b1;
                w_busy_nxt = 1'b1;
                w_lfsr_nxt = (w_pcnt_nxt != PAT_LAST);
                w_misr_nxt = (w_pcnt_nxt != {PCW{1'b0}});
            end
            S_CAPTURE: begin
                w_cap_nxt  = 1'b1;
                w_busy_nxt = 1'b1;
            end
            S_COMPARE: begin
                w_busy_nxt = 1'b1;
            end
            S_DONE: begin
                w_end_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // State, counters, result and registered control outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_shift_cnt    <= {SCW{1'b0}};
            r_start_q      <= 1'b0;
            pattern_cnt    <= {PCW{1'b0}};
            pass_nfail     <= 1'b0;
            lfsr_seed_load <= 1'b0;
            lfsr_en        <= 1'b0;
            scan_en        <= 1'b0;
            capture_en     <= 1'b0;
            misr_clear     <= 1'b0;
            misr_en        <= 1'b0;
            busy           <= 1'b0;
            bist_end       <= 1'b0;
`ifdef BIST_ABORT_EN
            aborted        <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_shift_cnt    <= w_shift_nxt;
            r_start_q      <= bist_start;
            pattern_cnt    <= w_pcnt_nxt;
            pass_nfail     <= w_pass_nxt;
            lfsr_seed_load <= w_seed_nxt;
            lfsr_en        <= w_lfsr_nxt;
            scan_en        <= w_scan_nxt;
            capture_en     <= w_cap_nxt;
            misr_clear     <= w_clr_nxt;
            misr_en        <= w_misr_nxt;
            busy           <= w_busy_nxt;
            bist_end       <= w_end_nxt;
`ifdef BIST_ABORT_EN
            aborted        <= w_aborted_nxt;
`endif
        end
    end

endmodule
